pack_pixel_blocks: RTL and testbench

PACK_PIXEL_BLOCKS -- requirements
Module: pack_pixel_blocks

---
 rtl/stereo_pkg.sv | 13 +
 rtl/block_line_accum.sv | 37 +++
 rtl/pack_pixel_blocks.sv | 115 +++++++++++
 tb/tb_pack_pixel_blocks.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/stereo_pkg.sv
// Purpose: shared image geometry for the stereo frame-buffer path (pack_pixel_blocks, update_buffers).
// Contents: image size, block height, pixel width, and the derived word/address widths.
// A BRAM word holds BLOCK vertically stacked pixels of one column.
package stereo_pkg;

  localparam int IMG_W  = 320;
  localparam int IMG_H  = 240;
  localparam int BLOCK  = 6;
  localparam int PIX_W  = 8;
  localparam int WORD_W = BLOCK * PIX_W;
  localparam int ADDR_W = $clog2(IMG_W * IMG_H / BLOCK);

endpackage

// File: rtl/block_line_accum.sv
// Purpose: one line of partial column words; holds the first BLOCK-1 pixels of each column.
// Ports: byte-lane write port (we/waddr/lane_we/wdata), read port with 1-cycle registered data.
// Contents are not reset; rdata_out holds its value between reads.
module block_line_accum #(
  parameter int N     = 320,
  parameter int LANES = 5,
  parameter int PIX_W = 8,
  parameter int AW    = $clog2(N)
) (
  input  logic                   clk_in,
  input  logic                   we_in,
  input  logic [AW-1:0]          waddr_in,
  input  logic [LANES-1:0]       lane_we_in,
  input  logic [LANES*PIX_W-1:0] wdata_in,
  input  logic                   re_in,
  input  logic [AW-1:0]          raddr_in,
  output logic [LANES*PIX_W-1:0] rdata_out
);

  logic [LANES*PIX_W-1:0] mem_q [N];
  logic [LANES*PIX_W-1:0] rdata_q;

  // A write in cycle t is visible to a read issued in cycle t+1, so the
  // write-then-read pattern of a column completing on consecutive pixels
  // returns the fresh byte without a separate forwarding path.
  always_ff @(posedge clk_in) begin
    if (we_in) begin
      for (int k = 0; k < LANES; k++) begin
        if (lane_we_in[k]) mem_q[waddr_in][k*PIX_W +: PIX_W] <= wdata_in[k*PIX_W +: PIX_W];
      end
    end
    if (re_in) rdata_q <= mem_q[raddr_in];
  end

  assign rdata_out = rdata_q;

endmodule

// File: rtl/pack_pixel_blocks.sv
// Purpose: pack a row-major pixel stream into BLOCK-pixel column words for the frame-buffer BRAM.
// Ports: clk_in/rst_in; valid_in, x_in, y_in, pixel_in in; we_out, addr_out, data_out, frame_done_out.
// Latency 2 cycles from the last pixel of a column block to we_out; one pixel/cycle, no backpressure.
module pack_pixel_blocks #(
  parameter int IMG_W = stereo_pkg::IMG_W,
  parameter int IMG_H = stereo_pkg::IMG_H,
  parameter int BLOCK = stereo_pkg::BLOCK,
  parameter int PIX_W = stereo_pkg::PIX_W,
  localparam int X_W    = $clog2(IMG_W) + 1,
  localparam int Y_W    = $clog2(IMG_H) + 1,
  localparam int ADDR_W = $clog2(IMG_W * IMG_H / BLOCK),
  localparam int WORD_W = BLOCK * PIX_W
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              valid_in,
  input  logic [X_W-1:0]    x_in,
  input  logic [Y_W-1:0]    y_in,
  input  logic [PIX_W-1:0]  pixel_in,
  output logic              we_out,
  output logic [ADDR_W-1:0] addr_out,
  output logic [WORD_W-1:0] data_out,
  output logic              frame_done_out
);

  localparam int LANES = BLOCK - 1;
  localparam int AW    = $clog2(IMG_W);

  // ---------------- decode (cycle 0) ----------------
  logic [Y_W-1:0]         sub, brow;
  logic                   in_range, acc_we, acc_re, last_px;
  logic [LANES-1:0]       lane_we;
  logic [ADDR_W-1:0]      addr_d;

  // Constant divisor: synthesis reduces these to fixed arithmetic.
  assign sub      = y_in % Y_W'(BLOCK);
  assign brow     = y_in / Y_W'(BLOCK);
  assign in_range = (x_in < X_W'(IMG_W)) && (y_in < Y_W'(IMG_H));
  assign acc_we   = valid_in && in_range && !rst_in && (sub != Y_W'(BLOCK - 1));
  assign acc_re   = valid_in && in_range && !rst_in && (sub == Y_W'(BLOCK - 1));
  assign last_px  = (x_in == X_W'(IMG_W - 1)) && (y_in == Y_W'(IMG_H - 1));
  assign addr_d   = ADDR_W'(x_in) + ADDR_W'(IMG_W) * ADDR_W'(brow);

  always_comb begin
    lane_we = '0;
    for (int k = 0; k < LANES; k++) lane_we[k] = (sub == Y_W'(k));
  end

  logic [LANES*PIX_W-1:0] acc_rdata;

  block_line_accum #(
    .N     (IMG_W),
    .LANES (LANES),
    .PIX_W (PIX_W),
    .AW    (AW)
  ) u_accum (
    .clk_in     (clk_in),
    .we_in      (acc_we),
    .waddr_in   (x_in[AW-1:0]),
    .lane_we_in (lane_we),
    .wdata_in   ({LANES{pixel_in}}),
    .re_in      (acc_re),
    .raddr_in   (x_in[AW-1:0]),
    .rdata_out  (acc_rdata)
  );

  // ---------------- stage 1: wait for accumulator read ----------------
  logic              vld1_q, last1_q;
  logic [ADDR_W-1:0] addr1_q;
  logic [PIX_W-1:0]  pix1_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      vld1_q  <= 1'b0;
      last1_q <= 1'b0;
      addr1_q <= '0;
      pix1_q  <= '0;
    end else begin
      vld1_q  <= acc_re;
      last1_q <= acc_re && last_px;
      if (acc_re) begin
        addr1_q <= addr_d;
        pix1_q  <= pixel_in;
      end
    end
  end

  // ---------------- stage 2: output registers ----------------
  logic              we_q, done_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0] data_q;

  // Address/data only move on a write so the BRAM port sees stable values between words.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      we_q   <= vld1_q;
      done_q <= last1_q;
      if (vld1_q) begin
        addr_q <= addr1_q;
        data_q <= {pix1_q, acc_rdata};
      end
    end
  end

  assign we_out         = we_q;
  assign frame_done_out = done_q;
  assign addr_out       = addr_q;
  assign data_out       = data_q;

endmodule

// File: tb/tb_pack_pixel_blocks.sv
// Purpose: self-checking bench for pack_pixel_blocks with a scoreboard of expected BRAM writes.
// Ports: none; drives the DUT from one initial block, a monitor pops expectations on each we_out.
// Expected words come from a bench-side model of the column accumulator.
module tb_pack_pixel_blocks;

  localparam int W = 320;
  localparam int H = 240;
  localparam int B = 6;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        valid_in = 1'b0;
  logic [9:0]  x_in = '0;
  logic [8:0]  y_in = '0;
  logic [7:0]  pixel_in = '0;
  logic        we_out;
  logic [13:0] addr_out;
  logic [47:0] data_out;
  logic        frame_done_out;

  pack_pixel_blocks dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .valid_in       (valid_in),
    .x_in           (x_in),
    .y_in           (y_in),
    .pixel_in       (pixel_in),
    .we_out         (we_out),
    .addr_out       (addr_out),
    .data_out       (data_out),
    .frame_done_out (frame_done_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [13:0] a;
    logic [47:0] d;
    logic        done;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] acc_m [W][B-1];
  int         n_pass = 0;
  int         n_total = 0;
  int         n_writes = 0;
  int         n_done = 0;

  // Scoreboard monitor: every write must match the oldest expectation.
  always @(negedge clk_in) begin
    if (we_out === 1'b1) begin
      exp_t e;
      exp_t got;
      n_writes++;
      if (frame_done_out === 1'b1) n_done++;
      n_total++;
      got = {addr_out, data_out, frame_done_out};
      if (sb.size() == 0) begin
        $display("FAIL unexpected_write: got addr=%0d data=%h done=%0b, required no write",
                 addr_out, data_out, frame_done_out);
      end else begin
        e = sb.pop_front();
        if (got !== e)
          $display("FAIL write_word: got addr=%0d data=%h done=%0b, required addr=%0d data=%h done=%0b",
                   addr_out, data_out, frame_done_out, e.a, e.d, e.done);
        else n_pass++;
      end
    end else if (frame_done_out !== 1'b0 && rst_in === 1'b0 && n_total > 0) begin
      n_total++;
      $display("FAIL done_without_write: got frame_done_out=%b with we_out=%b, required 0",
               frame_done_out, we_out);
    end
  end

  // Drive one pixel for one cycle; 'model' updates the reference accumulator/scoreboard.
  task automatic send(input int x, input int y, input int p, input bit model);
    valid_in = 1'b1;
    x_in     = 10'(x);
    y_in     = 9'(y);
    pixel_in = 8'(p);
    if (model && x < W && y < H) begin
      if (y % B < B - 1) begin
        acc_m[x][y % B] = 8'(p);
      end else begin
        exp_t e;
        e.a = 14'(x + W * (y / B));
        for (int k = 0; k < B - 1; k++) e.d[8*k +: 8] = acc_m[x][k];
        e.d[47:40] = 8'(p);
        e.done = (x == W - 1) && (y == H - 1);
        sb.push_back(e);
      end
    end
    @(posedge clk_in); #1;
    valid_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk_in); #1; end
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (sb.size() != 0 && t < 20) begin idle(1); t++; end
    idle(3);
    n_total++;
    if (sb.size() != 0) $display("FAIL %s_drain: got %0d pending writes, required 0", name, sb.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    idle(2);
    rst_in = 1'b0;
    n_total++;
    if ({we_out, frame_done_out, addr_out, data_out} !== 64'd0)
      $display("FAIL reset_outputs: got we=%b done=%b addr=%h data=%h, required all 0",
               we_out, frame_done_out, addr_out, data_out);
    else n_pass++;
  endtask

  task automatic test_column();
    for (int y = 0; y < B; y++) send(0, y, 8'h10 + y, 1'b1);
    drain("column");
    n_total++;
    if ({addr_out, data_out} !== {14'd0, 48'h151413121110})
      $display("FAIL column_hold: got addr=%0d data=%h, required addr=0 data=151413121110", addr_out, data_out);
    else n_pass++;
  endtask

  task automatic test_offset();
    for (int y = 6; y < 12; y++) send(1, y, 8'hA0 + y - 6, 1'b1);
    drain("offset");
    n_total++;
    if ({addr_out, data_out} !== {14'd321, 48'hA5A4A3A2A1A0})
      $display("FAIL offset_hold: got addr=%0d data=%h, required addr=321 data=a5a4a3a2a1a0", addr_out, data_out);
    else n_pass++;
    n_total++;
    if (we_out !== 1'b0) $display("FAIL offset_we_idle: got we=%b, required 0", we_out);
    else n_pass++;
  endtask

  task automatic test_range();
    int w0 = n_writes;
    for (int y = 0; y < B; y++) begin
      for (int x = 2; x < 5; x++) begin
        send(x, y, 8'h30 + 8*x + y, 1'b1);
        send(W, y, 8'hEE, 1'b1);
        send(x, H, 8'hEE, 1'b1);
        send(x, H + 5, 8'hEE, 1'b1);
      end
    end
    drain("range");
    n_total++;
    if (n_writes - w0 != 3) $display("FAIL range_write_count: got %0d, required 3", n_writes - w0);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int w0 = n_writes;
    // Last two rows of a block at the same column on consecutive cycles: write then read.
    for (int y = 0; y < B - 2; y++) send(7, y, 8'h70 + y, 1'b1);
    idle(2);
    send(7, B - 2, 8'h7E, 1'b1);
    send(7, B - 1, 8'h7F, 1'b1);
    drain("back_to_back");
    n_total++;
    if (n_writes - w0 != 1) $display("FAIL b2b_write_count: got %0d, required 1", n_writes - w0);
    else n_pass++;
  endtask

  task automatic test_reset_inflight();
    int w0;
    for (int y = 0; y < B - 1; y++) send(5, y, 8'h50 + y, 1'b1);
    w0 = n_writes;
    send(5, B - 1, 8'h55, 1'b0);
    rst_in = 1'b1;
    idle(1);
    rst_in = 1'b0;
    idle(4);
    n_total++;
    if (n_writes != w0) $display("FAIL reset_inflight_write: got %0d writes, required 0", n_writes - w0);
    else n_pass++;
    n_total++;
    if ({we_out, frame_done_out, addr_out, data_out} !== 64'd0)
      $display("FAIL reset_inflight_outputs: got we=%b done=%b addr=%h data=%h, required all 0",
               we_out, frame_done_out, addr_out, data_out);
    else n_pass++;
  endtask

  task automatic test_full_frame();
    int w0 = n_writes;
    int d0 = n_done;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        send(x, y, (x + y) & 8'hFF, 1'b1);
    drain("full_frame");
    n_total++;
    if (n_writes - w0 != 12800) $display("FAIL frame_write_count: got %0d, required 12800", n_writes - w0);
    else n_pass++;
    n_total++;
    if (n_done - d0 != 1) $display("FAIL frame_done_count: got %0d, required 1", n_done - d0);
    else n_pass++;
    n_total++;
    if (addr_out !== 14'd12799) $display("FAIL frame_last_addr: got %0d, required 12799", addr_out);
    else n_pass++;
  endtask

  initial begin
    idle(1);
    test_reset();
    test_column();
    test_offset();
    test_range();
    test_back_to_back();
    test_reset_inflight();
    test_full_frame();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
